// File: rtl/fault_test_sequencer.sv
// Vector-driven tester for a 4-input fault module: replays stored
// stimulus, waits a settle window, and records every response mismatch.
module fault_test_sequencer #(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [4:0]               wr_data,
  input  logic [$clog2(DEPTH):0]   num_vec,
  input  logic                     start,
  output logic                     dut_a,
  output logic                     dut_b,
  output logic                     dut_c,
  output logic                     dut_d,
  input  logic                     dut_x,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH):0]   fail_count,
  output logic [DEPTH-1:0]         fail_map,
  output logic [$clog2(DEPTH)-1:0] first_fail_idx,
  output logic                     first_fail_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SMAX = SW'(SETTLE > 0 ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic [CW-1:0] n;
  logic [CW-1:0] n_acc;
  logic [SW-1:0] cnt;
  logic          accept;
  logic          last;
  logic          miss;

  assign accept = (state == ST_IDLE) && start;
  assign n_acc  = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
  assign last   = ({1'b0, idx} == (n - 1'b1));
  assign miss   = (dut_x != mem[idx][0]);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (start)
          state_nxt = (n_acc == '0) ? ST_DONE : ST_APPLY;
      ST_APPLY:
        state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
      ST_SETTLE:
        if (cnt == SMAX) state_nxt = ST_SAMPLE;
      ST_SAMPLE:
        state_nxt = last ? ST_DONE : ST_APPLY;
      ST_DONE:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      {dut_a, dut_b, dut_c, dut_d} <= '0;
      idx              <= '0;
      n                <= '0;
      cnt              <= '0;
      pass             <= 1'b0;
      fail_count       <= '0;
      fail_map         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      if (state == ST_IDLE && wr_en) mem[wr_addr] <= wr_data;
      if (accept) begin
        n                <= n_acc;
        idx              <= '0;
        fail_count       <= '0;
        fail_map         <= '0;
        first_fail_idx   <= '0;
        first_fail_valid <= 1'b0;
        if (n_acc != '0) {dut_a, dut_b, dut_c, dut_d} <= mem[0][4:1];
        else             pass <= 1'b1;
      end
      if (state == ST_APPLY)  cnt <= '0;
      if (state == ST_SETTLE) cnt <= cnt + 1'b1;
      if (state == ST_SAMPLE) begin
        if (miss) begin
          fail_count    <= fail_count + 1'b1;
          fail_map[idx] <= 1'b1;
          if (!first_fail_valid) begin
            first_fail_idx   <= idx;
            first_fail_valid <= 1'b1;
          end
        end
        // pass is settled on entry to DONE so it is valid with done
        if (last) begin
          pass <= (fail_count == '0) && !miss;
        end else begin
          idx <= idx + 1'b1;
          {dut_a, dut_b, dut_c, dut_d} <= mem[idx + 1'b1][4:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fault_test_sequencer.sv
// Scoreboarded bench: runs push expected results, a monitor checks
// latency and results whenever done pulses.
module tb_fault_test_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [4:0]  num_vec;
  logic        start;
  logic        dut_a, dut_b, dut_c, dut_d;
  logic        dut_x;
  logic        busy, done, pass;
  logic [4:0]  fail_count;
  logic [15:0] fail_map;
  logic [3:0]  first_fail_idx;
  logic        first_fail_valid;

  int total = 0;
  int bad   = 0;
  int nchk  = 0;
  int cyc   = 0;
  bit stuck = 1'b0;

  typedef struct {
    int         lat;
    int         acc;
    bit         pass;
    int         fc;
    int         map;
    int         ffi;
    bit         ffv;
    logic [3:0] abcd;
  } exp_t;

  exp_t sb[$];

  fault_test_sequencer #(.DEPTH(16), .SETTLE(2)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d),
    .dut_x(dut_x), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_map(fail_map),
    .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign dut_x = stuck ? 1'b1 :
    (~(dut_a ^ dut_b) & (~dut_c | dut_d));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got 1 want 0");
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc, e.lat);
          @(negedge clock);
          chk("pass", pass, e.pass);
          chk("fail_count", fail_count, e.fc);
          chk("fail_map", fail_map, e.map);
          chk("first_fail_idx", first_fail_idx, e.ffi);
          chk("first_fail_valid", first_fail_valid, e.ffv);
          chk("abcd_hold", {dut_a, dut_b, dut_c, dut_d}, e.abcd);
          chk("busy_after", busy, 0);
          nchk++;
        end
      end
    end
  end

  task automatic wr(input int a, input logic [4:0] d);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_addr = a[3:0];
    wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic run_start(input int nv, input bit push, input exp_t e);
    exp_t t;
    t = e;
    @(negedge clock);
    num_vec = nv[4:0];
    start   = 1'b1;
    t.acc   = cyc + 1;
    if (push) sb.push_back(t);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_checked(input int target);
    int k = 0;
    while (nchk < target && k < 400) begin
      @(negedge clock);
      k++;
    end
    if (nchk < target) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got %0d want %0d", nchk, target);
      sb.delete();
    end
  endtask

  task automatic run(input int nv, input exp_t e);
    int target;
    target = nchk + 1;
    run_start(nv, 1'b1, e);
    wait_checked(target);
  endtask

  function automatic exp_t mk(input int lat, input bit p, input int fc,
                              input int map, input int ffi, input bit ffv,
                              input logic [3:0] abcd);
    exp_t e;
    e.lat  = lat;
    e.acc  = 0;
    e.pass = p;
    e.fc   = fc;
    e.map  = map;
    e.ffi  = ffi;
    e.ffv  = ffv;
    e.abcd = abcd;
    return e;
  endfunction

  logic [4:0] vecs [10] = '{
    5'b00011, 5'b11011, 5'b00001, 5'b11001, 5'b00111,
    5'b11111, 5'b10010, 5'b01010, 5'b00100, 5'b11100
  };

  initial begin : stim
    int target;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    num_vec = '0;
    start   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    repeat (5) begin
      @(negedge clock);
      chk("idle_busy", busy, 0);
      chk("idle_outs", {dut_a, dut_b, dut_c, dut_d, done, pass,
          fail_count, fail_map, first_fail_idx, first_fail_valid}, 0);
    end

    for (int i = 0; i < 10; i++) wr(i, vecs[i]);

    stuck = 1'b0;
    run(10, mk(40, 1, 0, 0, 0, 0, 4'b1110));

    stuck = 1'b1;
    run(10, mk(40, 0, 4, 16'h03C0, 6, 1, 4'b1110));

    stuck = 1'b0;
    run(0, mk(0, 1, 0, 0, 0, 0, 4'b1110));

    // entries 10..15 are still zero, which the good model answers with 1
    run(20, mk(64, 0, 6, 16'hFC00, 10, 1, 4'b0000));

    target = nchk + 1;
    run_start(10, 1'b1, mk(40, 1, 0, 0, 0, 0, 4'b1110));
    repeat (4) @(negedge clock);
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd9;
    wr_data = 5'b00000;
    @(negedge clock);
    start = 1'b0;
    wr_en = 1'b0;
    wait_checked(target);

    run_start(10, 1'b0, mk(0, 0, 0, 0, 0, 0, 4'b0000));
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {dut_a, dut_b, dut_c, dut_d, done, pass,
        fail_count, fail_map, first_fail_idx, first_fail_valid}, 0);

    run(16, mk(64, 0, 16, 16'hFFFF, 0, 1, 4'b0000));

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
